// File: rtl/sync_count_ctrl.sv
// sync_count_ctrl: sequencing controller for a loadable synchronous down counter.
// Loads the latched period into the counter, gates its count enable, flags
// terminal count, and supports one-shot / auto-reload runs with pause and abort.
//
// Handshake note: there is no valid/ready pair here. `start` is a request that
// is only accepted in IDLE; `abort` wins over everything else outside IDLE;
// `cnt_ld` and `cnt_en` are single-cycle commands the counter obeys on the
// next rising edge.
module sync_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_ld,
    output logic [WIDTH-1:0] cnt_ld_val,
    output logic             cnt_en,
    output logic             busy,
    output logic             tc_pulse,
    output logic             done,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_LOAD = 3'b001,
        S_RUN  = 3'b010,
        S_HOLD = 3'b011,
        S_DONE = 3'b100
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             reload_q, reload_d;

    logic             cnt_zero;
    assign cnt_zero = (cnt_q == '0);

    // Next-state, register captures and Mealy command outputs.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        reload_d = reload_q;
        cnt_ld   = 1'b0;
        cnt_en   = 1'b0;
        tc_pulse = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // period and mode are frozen here for the whole run
                    period_d = period;
                    reload_d = auto_reload;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_ld  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // abort beats terminal count, which beats pause
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_zero) begin
                    tc_pulse = 1'b1;
                    state_d  = reload_q ? S_LOAD : S_DONE;
                end else if (pause) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                // unused encodings recover to IDLE
                state_d = S_IDLE;
            end
        endcase
    end

    // State and run-parameter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            period_q <= '0;
            reload_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            reload_q <= reload_d;
        end
    end

    // done is a state decode; an abort landing in DONE still silences it.
    assign done       = (state_q == S_DONE) && !abort;
    assign busy       = (state_q != S_IDLE);
    assign cnt_ld_val = period_q;
    assign state      = state_q;

endmodule

// File: tb/tb_sync_count_ctrl.sv
// Directed self-checking bench for sync_count_ctrl with a small down-counter
// model closing the loop on cnt_ld / cnt_en / cnt_q.
module tb_sync_count_ctrl;

    localparam int W = 4;
    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_LOAD = 3'b001;
    localparam logic [2:0] ST_RUN  = 3'b010;
    localparam logic [2:0] ST_HOLD = 3'b011;
    localparam logic [2:0] ST_DONE = 3'b100;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         abort = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] period = '0;
    logic [W-1:0] cnt_q = '0;
    logic         cnt_ld;
    logic [W-1:0] cnt_ld_val;
    logic         cnt_en;
    logic         busy;
    logic         tc_pulse;
    logic         done;
    logic [2:0]   state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cycles = 0;

    sync_count_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .abort      (abort),
        .auto_reload(auto_reload),
        .period     (period),
        .cnt_q      (cnt_q),
        .cnt_ld     (cnt_ld),
        .cnt_ld_val (cnt_ld_val),
        .cnt_en     (cnt_en),
        .busy       (busy),
        .tc_pulse   (tc_pulse),
        .done       (done),
        .state      (state)
    );

    // clock
    always #5 clk = ~clk;

    // counter datapath model driven by the controller's commands
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cnt_en) en_cycles <= en_cycles + 1;
        if (cnt_ld) cnt_q <= cnt_ld_val;
        else if (cnt_en) cnt_q <= cnt_q - 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // check this cycle's outputs {ld,en,busy,tc,done,state}, then advance one clock
    task automatic step(input string tag, input logic ld, input logic en, input logic bsy,
                        input logic tc, input logic dn, input logic [2:0] st);
        #1;
        chk(tag, {24'd0, cnt_ld, cnt_en, bsy == bsy ? busy : 1'b0, tc_pulse, done, state},
            {24'd0, ld, en, bsy, tc, dn, st});
        @(posedge clk);
        #1;
    endtask

    task automatic run_oneshot(input int p, input string tag);
        int en0;
        period = p[W-1:0];
        auto_reload = 1'b0;
        start = 1'b1;
        step({tag, "_idle_start"}, 0, 0, 0, 0, 0, ST_IDLE);
        start = 1'b0;
        en0 = en_cycles;
        #1 chk({tag, "_ldval"}, {28'd0, cnt_ld_val}, p);
        step({tag, "_load"}, 1, 0, 1, 0, 0, ST_LOAD);
        for (int i = p; i >= 1; i--) begin
            chk({tag, "_cnt"}, {28'd0, cnt_q}, i);
            step({tag, "_run"}, 0, 1, 1, 0, 0, ST_RUN);
        end
        chk({tag, "_cnt0"}, {28'd0, cnt_q}, 0);
        step({tag, "_tc"}, 0, 0, 1, 1, 0, ST_RUN);
        step({tag, "_done"}, 0, 0, 1, 0, 1, ST_DONE);
        chk({tag, "_en_cycles"}, en_cycles - en0, p);
        step({tag, "_idle"}, 0, 0, 0, 0, 0, ST_IDLE);
    endtask

    initial begin
        int tc_prev;
        // reset held for 3 cycles, then idle with no start
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ldval", {28'd0, cnt_ld_val}, 0);
            step("rst_outs", 0, 0, 0, 0, 0, ST_IDLE);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("idle_ldval", {28'd0, cnt_ld_val}, 0);
            step("idle_outs", 0, 0, 0, 0, 0, ST_IDLE);
        end

        // one-shot, period 5
        run_oneshot(5, "os5");

        // auto-reload, period 3: tc every 5 cycles, then abort
        period = 4'd3;
        auto_reload = 1'b1;
        start = 1'b1;
        step("ar_start", 0, 0, 0, 0, 0, ST_IDLE);
        start = 1'b0;
        auto_reload = 1'b0;
        tc_prev = 0;
        for (int k = 0; k < 4; k++) begin
            step("ar_load", 1, 0, 1, 0, 0, ST_LOAD);
            for (int i = 3; i >= 1; i--) begin
                chk("ar_cnt", {28'd0, cnt_q}, i);
                step("ar_run", 0, 1, 1, 0, 0, ST_RUN);
            end
            chk("ar_cnt0", {28'd0, cnt_q}, 0);
            if (k > 0) chk("ar_tc_period", cyc - tc_prev, 5);
            tc_prev = cyc;
            step("ar_tc", 0, 0, 1, 1, 0, ST_RUN);
        end
        step("ar_load5", 1, 0, 1, 0, 0, ST_LOAD);
        chk("ar_cnt3", {28'd0, cnt_q}, 3);
        step("ar_run3", 0, 1, 1, 0, 0, ST_RUN);
        abort = 1'b1;
        chk("ar_cnt2", {28'd0, cnt_q}, 2);
        step("ar_abort", 0, 0, 1, 0, 0, ST_RUN);
        abort = 1'b0;
        step("ar_idle1", 0, 0, 0, 0, 0, ST_IDLE);
        step("ar_idle2", 0, 0, 0, 0, 0, ST_IDLE);
        chk("ar_cnt_kept", {28'd0, cnt_q}, 2);

        // pause, period 4: pause high for 3 cycles starting at cnt_q=2
        period = 4'd4;
        start = 1'b1;
        step("pz_start", 0, 0, 0, 0, 0, ST_IDLE);
        start = 1'b0;
        step("pz_load", 1, 0, 1, 0, 0, ST_LOAD);
        step("pz_run4", 0, 1, 1, 0, 0, ST_RUN);
        step("pz_run3", 0, 1, 1, 0, 0, ST_RUN);
        pause = 1'b1;
        chk("pz_cnt2a", {28'd0, cnt_q}, 2);
        step("pz_run2p", 0, 0, 1, 0, 0, ST_RUN);
        step("pz_hold1", 0, 0, 1, 0, 0, ST_HOLD);
        chk("pz_cnt2b", {28'd0, cnt_q}, 2);
        step("pz_hold2", 0, 0, 1, 0, 0, ST_HOLD);
        pause = 1'b0;
        chk("pz_cnt2c", {28'd0, cnt_q}, 2);
        step("pz_hold_rel", 0, 0, 1, 0, 0, ST_HOLD);
        chk("pz_cnt2d", {28'd0, cnt_q}, 2);
        step("pz_run2", 0, 1, 1, 0, 0, ST_RUN);
        step("pz_run1", 0, 1, 1, 0, 0, ST_RUN);
        chk("pz_cnt0", {28'd0, cnt_q}, 0);
        step("pz_tc", 0, 0, 1, 1, 0, ST_RUN);
        step("pz_done", 0, 0, 1, 0, 1, ST_DONE);
        step("pz_idle", 0, 0, 0, 0, 0, ST_IDLE);

        // pause together with cnt_q=0: tc still fires, go to DONE
        period = 4'd1;
        start = 1'b1;
        step("cp_start", 0, 0, 0, 0, 0, ST_IDLE);
        start = 1'b0;
        step("cp_load", 1, 0, 1, 0, 0, ST_LOAD);
        step("cp_run1", 0, 1, 1, 0, 0, ST_RUN);
        pause = 1'b1;
        step("cp_tc_pause", 0, 0, 1, 1, 0, ST_RUN);
        pause = 1'b0;
        step("cp_done", 0, 0, 1, 0, 1, ST_DONE);
        step("cp_idle", 0, 0, 0, 0, 0, ST_IDLE);

        // abort together with cnt_q=0: no tc, straight to IDLE
        start = 1'b1;
        step("ca_start", 0, 0, 0, 0, 0, ST_IDLE);
        start = 1'b0;
        step("ca_load", 1, 0, 1, 0, 0, ST_LOAD);
        step("ca_run1", 0, 1, 1, 0, 0, ST_RUN);
        abort = 1'b1;
        step("ca_abort_tc", 0, 0, 1, 0, 0, ST_RUN);
        abort = 1'b0;
        step("ca_idle", 0, 0, 0, 0, 0, ST_IDLE);

        // start while busy is ignored; latched period and mode unchanged
        period = 4'd2;
        start = 1'b1;
        step("cs_start", 0, 0, 0, 0, 0, ST_IDLE);
        period = 4'd9;
        auto_reload = 1'b1;
        #1 chk("cs_ldval_load", {28'd0, cnt_ld_val}, 2);
        step("cs_load", 1, 0, 1, 0, 0, ST_LOAD);
        chk("cs_ldval_run", {28'd0, cnt_ld_val}, 2);
        step("cs_run2", 0, 1, 1, 0, 0, ST_RUN);
        step("cs_run1", 0, 1, 1, 0, 0, ST_RUN);
        start = 1'b0;
        step("cs_tc", 0, 0, 1, 1, 0, ST_RUN);
        step("cs_done", 0, 0, 1, 0, 1, ST_DONE);
        chk("cs_ldval_after", {28'd0, cnt_ld_val}, 2);
        step("cs_idle", 0, 0, 0, 0, 0, ST_IDLE);

        // edge values
        run_oneshot(0, "os0");
        run_oneshot(15, "os15");

        // reset pulled low mid-run: immediate return to reset state
        period = 4'd6;
        auto_reload = 1'b0;
        start = 1'b1;
        step("mr_start", 0, 0, 0, 0, 0, ST_IDLE);
        start = 1'b0;
        step("mr_load", 1, 0, 1, 0, 0, ST_LOAD);
        step("mr_run6", 0, 1, 1, 0, 0, ST_RUN);
        #2 reset = 1'b0;
        #1 chk("mr_async_outs", {24'd0, cnt_ld, cnt_en, busy, tc_pulse, done, state}, 0);
        chk("mr_async_ldval", {28'd0, cnt_ld_val}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        step("mr_idle1", 0, 0, 0, 0, 0, ST_IDLE);
        step("mr_idle2", 0, 0, 0, 0, 0, ST_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
